// File: rtl/mdu_pkg.sv
// Shared definitions for the M-extension sequencer: ALUop codes, FSM states
// and small op-classification helpers.
package mdu_pkg;

  localparam logic [4:0] MDU_MUL   = 5'd15;
  localparam logic [4:0] MDU_MULW  = 5'd16;
  localparam logic [4:0] MDU_DIVW  = 5'd17;
  localparam logic [4:0] MDU_REMW  = 5'd18;
  localparam logic [4:0] MDU_DIVUW = 5'd19;
  localparam logic [4:0] MDU_REMUW = 5'd20;
  localparam logic [4:0] MDU_DIVU  = 5'd21;
  localparam logic [4:0] MDU_REMU  = 5'd22;
  localparam logic [4:0] MDU_DIV   = 5'd23;
  localparam logic [4:0] MDU_REM   = 5'd24;

  // Quotient returned on divide by zero.
  localparam logic [63:0] DIV_ALL_ONES = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_t;

  function automatic logic is_valid_op(input logic [4:0] op);
    return (op >= MDU_MUL) && (op <= MDU_REM);
  endfunction

  // W forms operate on the low 32 bits and sign-extend the 32-bit result.
  function automatic logic is_word_op(input logic [4:0] op);
    return (op >= MDU_MULW) && (op <= MDU_REMUW);
  endfunction

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == MDU_MUL) || (op == MDU_MULW);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == MDU_REMW) || (op == MDU_REMUW) || (op == MDU_REMU) || (op == MDU_REM);
  endfunction

  function automatic logic is_signed_div_op(input logic [4:0] op);
    return (op == MDU_DIVW) || (op == MDU_REMW) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// One iteration of the multi-cycle datapath: a single shift-add multiply step
// or a single restoring shift-subtract divide step.
//   multiply: acc += x when y[0]; x <<= 1; y >>= 1
//   divide:   acc = partial remainder, x = dividend bits shifting out with
//             quotient bits shifting in, y = divisor (unchanged)
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            is_div_i,
  input  logic [XLEN:0]   acc_i,
  input  logic [XLEN-1:0] x_i,
  input  logic [XLEN-1:0] y_i,
  output logic [XLEN:0]   acc_o,
  output logic [XLEN-1:0] x_o,
  output logic [XLEN-1:0] y_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Next-step values; remainder needs one extra bit since it may reach 2*divisor-1.
  always_comb begin
    shifted = {acc_i[XLEN-1:0], x_i[XLEN-1]};
    diff    = shifted - {1'b0, y_i};
    acc_o   = acc_i;
    x_o     = x_i;
    y_o     = y_i;
    if (is_div_i) begin
      if (shifted >= {1'b0, y_i}) begin
        acc_o = diff;
        x_o   = {x_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = shifted;
        x_o   = {x_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = y_i[0] ? (acc_i + {1'b0, x_i}) : acc_i;
      x_o   = {x_i[XLEN-2:0], 1'b0};
      y_o   = {1'b0, y_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle M-extension sequencer: FSM, iteration counter, operand prep,
// special-case handling and final sign fix. Stalls the pipeline until the
// result is delivered for one cycle in DONE.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [OPW-1:0]  op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stallreq_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  mdu_state_t      state_q;
  logic [6:0]      cnt_q;
  logic [OPW-1:0]  op_q;
  logic [XLEN:0]   acc_q;
  logic [XLEN-1:0] x_q;
  logic [XLEN-1:0] y_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic [XLEN-1:0] result_q;
  logic            done_q;

  logic [XLEN:0]   acc_d;
  logic [XLEN-1:0] x_d;
  logic [XLEN-1:0] y_d;

  logic            in_word;
  logic            in_sdiv;
  logic            in_unsigned_w;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] div_x_init;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_raw;
  logic [XLEN-1:0] special_val;
  logic [XLEN-1:0] min_val;

  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] sel_fix;
  logic [XLEN-1:0] fix_val;

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .is_div_i (state_q == ST_DIV),
    .acc_i    (acc_q),
    .x_i      (x_q),
    .y_i      (y_q),
    .acc_o    (acc_d),
    .x_o      (x_d),
    .y_o      (y_d)
  );

  // Operand prep at latch time: width select, extension, magnitudes and special cases.
  always_comb begin
    in_word       = is_word_op(op_i);
    in_sdiv       = is_signed_div_op(op_i);
    in_unsigned_w = (op_i == MDU_DIVUW) || (op_i == MDU_REMUW);
    if (in_word) begin
      a_ext = in_unsigned_w ? {{(XLEN-32){1'b0}}, a_i[31:0]} : {{(XLEN-32){a_i[31]}}, a_i[31:0]};
      b_ext = in_unsigned_w ? {{(XLEN-32){1'b0}}, b_i[31:0]} : {{(XLEN-32){b_i[31]}}, b_i[31:0]};
      min_val = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      a_ext   = a_i;
      b_ext   = b_i;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg = in_sdiv & a_ext[XLEN-1];
    b_neg = in_sdiv & b_ext[XLEN-1];
    a_mag = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag = b_neg ? (~b_ext + 1'b1) : b_ext;
    // W dividends start in the upper half so 32 steps consume exactly their bits.
    div_x_init = in_word ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
    div_zero   = (b_ext == '0);
    div_ovf    = in_sdiv && (b_ext == '1) && (a_ext == min_val);
    special    = !is_mul_op(op_i) && (div_zero || div_ovf);
    if (is_rem_op(op_i)) begin
      special_raw = div_zero ? a_ext : '0;
    end else begin
      special_raw = div_zero ? DIV_ALL_ONES[XLEN-1:0] : a_ext;
    end
    special_val = in_word ? {{(XLEN-32){special_raw[31]}}, special_raw[31:0]} : special_raw;
  end

  // Final sign correction and result selection applied in FIX.
  always_comb begin
    quo_fix = q_neg_q ? (~x_q + 1'b1) : x_q;
    rem_fix = r_neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    if (is_mul_op(op_q)) begin
      sel_fix = acc_q[XLEN-1:0];
    end else if (is_rem_op(op_q)) begin
      sel_fix = rem_fix;
    end else begin
      sel_fix = quo_fix;
    end
    fix_val = is_word_op(op_q) ? {{(XLEN-32){sel_fix[31]}}, sel_fix[31:0]} : sel_fix;
  end

  // Sequencer FSM with registered done/result; flush aborts from any state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i && is_valid_op(op_i)) begin
            op_q    <= op_i;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            acc_q   <= '0;
            cnt_q   <= in_word ? 7'd32 : 7'd64;
            if (special) begin
              result_q <= special_val;
              done_q   <= 1'b1;
              cnt_q    <= '0;
              state_q  <= ST_DONE;
            end else if (is_mul_op(op_i)) begin
              x_q     <= a_ext;
              y_q     <= b_ext;
              state_q <= ST_MUL;
            end else begin
              x_q     <= div_x_init;
              y_q     <= b_mag;
              state_q <= ST_DIV;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          acc_q <= acc_d;
          x_q   <= x_d;
          y_q   <= y_d;
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_q <= fix_val;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stall covers the accepting cycle and every compute cycle; released in DONE.
  always_comb begin
    stallreq_o = !flush_i &&
                 (((state_q == ST_IDLE) && start_i && is_valid_op(op_i)) ||
                  (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX));
    busy_o     = (state_q != ST_IDLE);
  end

  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: an arithmetic reference model predicts
// timing and results per transaction; a per-cycle compare process checks the
// DUT outputs, and directed runs also check hand-computed literals.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [4:0]  op_i = '0;
  logic [63:0] a_i = '0;
  logic [63:0] b_i = '0;
  logic        stallreq_o;
  logic        busy_o;
  logic        done_o;
  logic [63:0] result_o;

  mdu_ctrl #(.XLEN(64), .OPW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_d = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state for the transaction in flight.
  bit          m_active = 1'b0;
  int          m_start  = 0;
  int          m_done   = 0;
  logic [63:0] m_res    = '0;
  logic [63:0] m_last   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // RISC-V M-extension results computed with plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] wa;
    logic signed [31:0] wb;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] t32;
    logic [63:0] r;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    t32 = '0; r = '0;
    case (op)
      5'd15: r = a * b;
      5'd16: begin t32 = ua * ub; r = sext32(t32); end
      5'd17: begin
        if (wb == 0) t32 = '1;
        else if (wa == 32'sh80000000 && wb == -1) t32 = wa;
        else t32 = wa / wb;
        r = sext32(t32);
      end
      5'd18: begin
        if (wb == 0) t32 = wa;
        else if (wa == 32'sh80000000 && wb == -1) t32 = '0;
        else t32 = wa % wb;
        r = sext32(t32);
      end
      5'd19: begin t32 = (ub == 0) ? 32'hFFFF_FFFF : ua / ub; r = sext32(t32); end
      5'd20: begin t32 = (ub == 0) ? ua : ua % ub; r = sext32(t32); end
      5'd21: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      5'd22: r = (b == 0) ? a : a % b;
      5'd23: begin
        if (sb == 0) r = '1;
        else if (sa == 64'sh8000000000000000 && sb == -1) r = sa;
        else r = sa / sb;
      end
      5'd24: begin
        if (sb == 0) r = sa;
        else if (sa == 64'sh8000000000000000 && sb == -1) r = '0;
        else r = sa % sb;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Cycle offset from the accepting cycle to the done_o cycle.
  function automatic int ref_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    bit word;
    bit isdiv;
    bit sgn;
    bit zero;
    bit ovf;
    word  = (op >= 5'd16) && (op <= 5'd20);
    isdiv = (op >= 5'd17);
    sgn   = (op == 5'd17) || (op == 5'd18) || (op == 5'd23) || (op == 5'd24);
    zero  = word ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf   = sgn && (word ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                         : ((a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF)));
    if (isdiv && (zero || ovf)) return 1;
    return word ? 34 : 66;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_done;
      bit e_busy;
      bit e_stall;
      if (!rst_d) m_last = '0;
      e_done  = m_active && (cyc == m_done);
      e_busy  = m_active && (cyc > m_start) && (cyc <= m_done);
      e_stall = !flush_i && m_active && (cyc >= m_start) && (cyc < m_done);
      if (e_done) m_last = m_res;
      check("done_o", 64'(done_o), 64'(e_done));
      check("busy_o", 64'(busy_o), 64'(e_busy));
      check("stallreq_o", 64'(stallreq_o), 64'(e_stall));
      check("result_o", result_o, m_last);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    start_i  = 1'b1;
    op_i     = op;
    a_i      = a;
    b_i      = b;
    m_start  = cyc;
    m_done   = cyc + ref_lat(op, a, b);
    m_res    = ref_result(op, a, b);
    m_active = 1'b1;
  endtask

  // Holds start_i through DONE, as the retiring instruction would.
  task automatic run_op(input string name, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] lit);
    int lat;
    lat = ref_lat(op, a, b);
    begin_op(op, a, b);
    repeat (lat) step();
    check({name, "_lit"}, result_o, lit);
    check({name, "_done"}, 64'(done_o), 64'd1);
    $display("op=%s a=%h b=%h result=%h lat=%0d", name, a, b, result_o, lat);
    step();
    m_active = 1'b0;
  endtask

  task automatic idle(input int n);
    start_i = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("reset_result", result_o, 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_stall", 64'(stallreq_o), 64'd0);
    chk_en = 1'b1;

    run_op("mul", 5'd15, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    idle(2);
    run_op("divw_ovf", 5'd17, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    idle(1);
    run_op("remw_ovf", 5'd18, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    idle(1);
    // Back-to-back: second start accepted in the IDLE cycle right after DONE.
    run_op("divu_by0", 5'd21, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu_by0", 5'd22, 64'd100, 64'd0, 64'd100);
    idle(1);
    run_op("rem", 5'd24, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    run_op("div", 5'd23, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    idle(1);
    run_op("remuw", 5'd20, 64'h0000_0001_0000_0007, 64'd3, 64'd1);
    idle(1);
    run_op("divw", 5'd17, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    idle(1);
    run_op("divuw", 5'd19, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    run_op("divu", 5'd21, 64'd1000, 64'd7, 64'd142);
    idle(1);
    run_op("rem_ovf", 5'd24, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    idle(1);

    // Invalid op code is ignored.
    start_i = 1'b1; op_i = 5'd25; a_i = 64'd5; b_i = 64'd3;
    step();
    check("invalid_op_busy", 64'(busy_o), 64'd0);
    idle(1);

    // Flush in the middle of a divide: IDLE next cycle, no done_o ever.
    begin_op(5'd23, 64'd1000, 64'd7);
    repeat (10) step();
    flush_i = 1'b1;
    step();
    flush_i  = 1'b0;
    start_i  = 1'b0;
    m_active = 1'b0;
    check("flush_busy", 64'(busy_o), 64'd0);
    $display("op=flush_div aborted at cyc=%0d", cyc);
    idle(80);

    // Start together with flush in IDLE is not accepted.
    start_i = 1'b1; op_i = 5'd21; a_i = 64'd9; b_i = 64'd2; flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    start_i = 1'b0;
    check("flush_start_busy", 64'(busy_o), 64'd0);
    idle(3);

    // Reset in the middle of a multiply.
    begin_op(5'd15, 64'd5, 64'd9);
    repeat (20) step();
    rst = 1'b0;
    start_i = 1'b0;
    step();
    rst = 1'b1;
    m_active = 1'b0;
    check("rst_mid_result", result_o, 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_done", 64'(done_o), 64'd0);
    $display("op=reset_mul aborted at cyc=%0d", cyc);
    idle(2);

    run_op("mulw", 5'd16, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(5);
    check("single_op_busy", 64'(busy_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
